// File: rtl/ula_pkg.sv
// Shared ULA opcodes, controller FSM encoding and instruction field layout.
// Pure declarations: no latency, no flow control.
package ula_pkg;

  localparam int W    = 8;
  localparam int NREG = 4;
  localparam int RW   = 2;
  localparam int OPW  = 4;
  localparam int NOPS = 10;

  localparam int OP_HI = 7;
  localparam int OP_LO = 4;
  localparam int RA_HI = 3;
  localparam int RA_LO = 2;
  localparam int RB_HI = 1;
  localparam int RB_LO = 0;

  typedef enum logic [OPW-1:0] {
    OP_NOT = 4'd0,
    OP_AND = 4'd1,
    OP_OR  = 4'd2,
    OP_XOR = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_SLR = 4'd6,
    OP_SRR = 4'd7,
    OP_MUL = 4'd8,
    OP_ROL = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam logic [OPW-1:0] NOPS_OP = OPW'(NOPS);

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return op < NOPS_OP;
  endfunction

endpackage

// File: rtl/ula_seq_regfile.sv
// 4x8 register file: sync write (writeback beats load), two operand reads and a debug read, all combinational.
// Write lands on the next edge; no backpressure, the controller guarantees load and writeback never overlap.
module ula_seq_regfile
  import ula_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_en,
  input  logic [RW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic [RW-1:0] rd_a_addr,
  input  logic [RW-1:0] rd_b_addr,
  input  logic [RW-1:0] dbg_addr,
  output logic [W-1:0]  rd_a_data,
  output logic [W-1:0]  rd_b_data,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end else if (ld_en) begin
      regs[ld_addr] <= ld_data;
    end
  end

  assign rd_a_data = regs[rd_a_addr];
  assign rd_b_data = regs[rd_b_addr];
  assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/ula_seq_ctrl.sv
// ULA sequencer IDLE->READ->EXEC->WB over a 4x8 regfile; ULA_SEQ_CTRL_STATS_EN adds a 16-bit retire counter.
// done 3 cycles after accept, one instr per 4 cycles; instr_ready low while busy or while ld_en is high.
module ula_seq_ctrl
  import ula_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [7:0]     instr,
  input  logic           ld_en,
  input  logic [RW-1:0]  ld_addr,
  input  logic [W-1:0]   ld_data,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_sel,
  input  logic [W-1:0]   alu_s,
  output logic           zero,
  output logic           busy,
  output logic           done,
  output logic           err,
  input  logic [RW-1:0]  dbg_addr,
  output logic [W-1:0]   dbg_data,
  output logic [15:0]    instr_cnt
);

  state_t         state;
  logic [OPW-1:0] op_q;
  logic [RW-1:0]  ra_q;
  logic [RW-1:0]  rb_q;
  logic [W-1:0]   result_q;
  logic [W-1:0]   rd_a_data;
  logic [W-1:0]   rd_b_data;
  logic           wb_en;
  logic           load_en;

  // Loads are only honoured in IDLE and take precedence over a pending instruction.
  assign instr_ready = (state == ST_IDLE) && !ld_en;
  assign load_en     = (state == ST_IDLE) && ld_en;
  assign wb_en       = (state == ST_WB);
  assign busy        = (state != ST_IDLE);

  ula_seq_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .ld_en     (load_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .wb_en     (wb_en),
    .wb_addr   (ra_q),
    .wb_data   (result_q),
    .rd_a_addr (ra_q),
    .rd_b_addr (rb_q),
    .dbg_addr  (dbg_addr),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .dbg_data  (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      result_q <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      zero     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            op_q  <= instr[OP_HI:OP_LO];
            ra_q  <= instr[RA_HI:RA_LO];
            rb_q  <= instr[RB_HI:RB_LO];
            state <= ST_READ;
          end
        end
        ST_READ: begin
          // Operands are presented even for an illegal opcode; only writeback is suppressed.
          alu_a   <= rd_a_data;
          alu_b   <= rd_b_data;
          alu_sel <= op_q;
          if (op_legal(op_q)) begin
            state <= ST_EXEC;
          end else begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          result_q <= alu_s;
          done     <= 1'b1;
          state    <= ST_WB;
        end
        ST_WB: begin
          zero  <= (result_q == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ULA_SEQ_CTRL_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state == ST_WB) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule
